br_resolve_q: RTL
=================

# br_resolve_q

In-order branch resolution queue: the write side of the 2-bit direction predictor. Each fetched branch pushes its prediction (PC, predicted direction, predicted target). Retire resolves the oldest entry with the actual outcome. The queue drives the predictor's training port (`upd_en`/`upd_take`, wired to the predictor's `enable`/`take`) and raises a registered mispredict/redirect that flushes younger in-flight branches.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `IDX_W`, 5: predictor index width; index = `pc[IDX_W+1:2]`.
- `XLEN`, 32: PC/target width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  fetch has a branch to record.
- `push_pc`  in  XLEN  branch PC.
- `push_pred_take`  in  1  predicted direction.
- `push_pred_target`  in  XLEN  predicted target.
- `push_ready`  out  1  `!full`; a push is accepted only when `push_valid && push_ready` and no flush is occurring this cycle.
- `rs_valid`  in  1  retire resolves the head entry this cycle.
- `rs_take`  in  1  actual direction.
- `rs_target`  in  XLEN  actual taken target.
- `upd_en`  out  1  predictor training strobe, registered.
- `upd_idx`  out  IDX_W  predictor index to train, registered.
- `upd_take`  out  1  actual outcome to train with, registered.
- `mispredict`  out  1  one-cycle registered pulse.
- `redirect_pc`  out  XLEN  correct next PC, valid while `mispredict`.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `empty`  out  1  `count==0`.
- `full`  out  1  `count==DEPTH`.

## Operation
- Storage: circular buffer of `DEPTH` entries `{pc, pred_take, pred_target}`, with `head`, `tail` and a `count` register. Pointers wrap modulo `DEPTH`.
- Push: the entry is written at `tail`, then `tail+1`.
- Resolve: valid only when `!empty`. `rs_valid` while empty is ignored: no pop, no update, no mispredict.
- On an accepted resolve, the head entry `e` is evaluated as follows.
  - `upd_en<=1`, `upd_idx<=e.pc[IDX_W+1:2]`, `upd_take<=rs_take`.
  - `miss = (e.pred_take != rs_take) || (rs_take && e.pred_take && e.pred_target != rs_target)`. The target term applies only when the macro is defined.
  - If `miss`: `mispredict<=1`. `redirect_pc <= rs_take ? rs_target : e.pc+4`. All entries are discarded: `head<=0`, `tail<=0`, `count<=0`. Any push in the same cycle is dropped.
  - If no miss: `head<=head+1` and `count` decrements, unless a push is also accepted, in which case `count` is unchanged.
- Push on a full queue is not accepted. The resolve that frees a slot does not raise `push_ready` in the same cycle.
- No FSM beyond the pointers. `mispredict` and `upd_en` are single-cycle pulses that default to 0 every cycle.

## Timing
- Reset values: `upd_en=0`, `upd_idx=0`, `upd_take=0`, `mispredict=0`, `redirect_pc=0`, `count=0`, `empty=1`, `full=0`, `push_ready=1`. Pointers are 0. Entry contents are don't-care.
- Reset asserted mid-operation discards every entry. No update or mispredict pulse is produced for that cycle.
- Latency from a resolve in cycle N:
  - `upd_*` and `mispredict`/`redirect_pc` are visible in cycle N+1.
  - The queue shows empty in N+1 after a miss.
  - Pushes are accepted again in N+1.
- `count`, `empty`, `full` and `push_ready` are functions of registered state only. They do not depend combinationally on `push_valid` or `rs_valid`.
- Simultaneous push and resolve on a non-full queue with no miss: both take effect and `count` is unchanged.

## Configuration
- Macro: `BR_RESOLVE_TARGET_CHECK_EN`.
  - Defined: `pred_target` is stored. A correctly predicted taken branch whose predicted target differs from the actual target is a miss, redirecting to `rs_target`.
  - Undefined: `pred_target` is not stored and `push_pred_target` is unused. A miss is a direction mismatch only.
- The `upd_*` behaviour is identical in both builds.

## Structure
- Shared package `bp_pkg` holds:
  - `ts_state` (the 2-bit counter enum);
  - the entry struct `br_entry_t`;
  - the width constants `BP_IDX_W` and `BP_XLEN`.
- No sub-module; the storage and compare logic stay inline.
- Integration instantiates this block beside the predictor table, not inside it.

## Test plan
- Reset, then idle: `empty=1`, `push_ready=1`, `upd_en=0`, `mispredict=0` on every cycle.
- Push PC `0x100`, pred not-taken. Resolve not-taken -> next cycle `upd_en=1`, `upd_idx=0x00`, `upd_take=0`, `mispredict=0`, `count=0`.
- Push 8 entries: `full=1`, `push_ready=0`, and a 9th push is ignored. One resolve (hit) -> `count=7` and `push_ready=1` the following cycle.
- Push `0x104` pred taken to `0x200`, then push `0x108`. Resolve not-taken -> next cycle `mispredict=1`, `redirect_pc=0x108`, `upd_idx=0x01`, `upd_take=0`, `count=0`. A push during the resolve cycle is dropped.
- Target check (macro defined): push `0x10C` pred taken to `0x300`, resolve taken with `rs_target=0x340` -> `mispredict=1`, `redirect_pc=0x340`. With the macro undefined -> `mispredict=0`.
- `rs_valid` while empty -> no `upd_en` or `mispredict`. Simultaneous push and resolve at `count=3` -> `count` stays 3 and FIFO order is preserved.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor types and widths.
// Contents:
//   ts_state   - 2-bit saturating direction counter encoding
//   br_entry_t - one branch resolution queue entry
//   BP_IDX_W   - predictor index width
//   BP_XLEN    - PC/target width
// Macro BR_RESOLVE_TARGET_CHECK_EN adds pred_target to br_entry_t.
package bp_pkg;

    localparam int BP_IDX_W = 5;
    localparam int BP_XLEN  = 32;

    typedef enum logic [1:0] {
        TS_SNT = 2'd0,
        TS_WNT = 2'd1,
        TS_WT  = 2'd2,
        TS_ST  = 2'd3
    } ts_state;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               pred_take;
`ifdef BR_RESOLVE_TARGET_CHECK_EN
        logic [BP_XLEN-1:0] pred_target;
`endif
    } br_entry_t;

endpackage

// File: rtl/br_resolve_q.sv
// br_resolve_q: in-order branch resolution queue feeding predictor training and redirect.
// Ports:
//   clock, reset                      - rising-edge clock, synchronous active-high reset
//   push_valid/pc/pred_take/pred_target, push_ready - fetch records a predicted branch
//   rs_valid/rs_take/rs_target        - retire resolves the oldest entry
//   upd_en/upd_idx/upd_take           - registered predictor training strobe
//   mispredict/redirect_pc            - registered one-cycle redirect pulse
//   count/empty/full                  - occupancy, from registered state only
// Macro BR_RESOLVE_TARGET_CHECK_EN: store predicted targets and treat a
// correctly-predicted taken branch with a wrong target as a miss.
module br_resolve_q
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = BP_IDX_W,
    parameter int XLEN  = BP_XLEN
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [XLEN-1:0]            push_pc,
    input  logic                       push_pred_take,
    input  logic [XLEN-1:0]            push_pred_target,
    output logic                       push_ready,
    input  logic                       rs_valid,
    input  logic                       rs_take,
    input  logic [XLEN-1:0]            rs_target,
    output logic                       upd_en,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_take,
    output logic                       mispredict,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    br_entry_t       mem [DEPTH];
    br_entry_t       e;
    logic [PW-1:0]   head, tail;
    logic            rs_ok, miss, flush, push_ok;

    assign e          = mem[head];
    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    assign push_ready = !full;
    assign rs_ok      = rs_valid && !empty;

`ifdef BR_RESOLVE_TARGET_CHECK_EN
    assign miss = (e.pred_take != rs_take) || (rs_take && e.pred_take && e.pred_target != rs_target);
`else
    assign miss = e.pred_take != rs_take;
    logic unused_target;
    assign unused_target = ^push_pred_target;
`endif

    // A miss squashes every younger branch, including one arriving this cycle.
    assign flush   = rs_ok && miss;
    assign push_ok = push_valid && push_ready && !flush;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[tail].pc        <= push_pc;
            mem[tail].pred_take <= push_pred_take;
`ifdef BR_RESOLVE_TARGET_CHECK_EN
            mem[tail].pred_target <= push_pred_target;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            upd_en      <= 1'b0;
            upd_idx     <= '0;
            upd_take    <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_en     <= rs_ok;
            mispredict <= flush;
            if (rs_ok) begin
                upd_idx  <= e.pc[IDX_W+1:2];
                upd_take <= rs_take;
            end
            if (flush) begin
                redirect_pc <= rs_take ? rs_target : e.pc + XLEN'(4);
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (rs_ok)
                    head <= head + 1'b1;
                if (push_ok)
                    tail <= tail + 1'b1;
                count <= count + CW'(push_ok) - CW'(rs_ok);
            end
        end
    end

endmodule
